icache_plru_tree: RTL and testbench

- Parametrised tree pseudo-LRU replacement engine for the set-associative instruction cache. Successor to the fixed 8-way/64-set PLRU.
- Holds one (WAYS-1)-bit tree per set in flops and applies MRU updates on cache hits.
- Serves victim requests from the refill path through a valid/ready request and a registered valid/ready response. The chosen victim is touched automatically.
- Adds a sequenced flush sweep. Optionally selects an invalid way before consulting the tree.

---
 rtl/icache_plru_tree.sv | 143 ++++++++++++++
 tb/tb_icache_plru_tree.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_plru_tree.sv
// Tree pseudo-LRU replacement engine: per-set heap-ordered PLRU trees, hit touches,
// registered victim responses and a flush sweep. ICACHE_PLRU_INVALID_FIRST_EN adds invalid-way-first.
module icache_plru_tree #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_valid_i,
  output logic             plru_busy_o,
  input  logic             hit_valid_i,
  input  logic [IDX_W-1:0] hit_index_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             rep_req_valid_i,
  output logic             rep_req_ready_o,
  input  logic [IDX_W-1:0] rep_req_index_i,
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
  input  logic [WAYS-1:0]  rep_req_vmask_i,
`endif
  output logic             rep_resp_valid_o,
  input  logic             rep_resp_ready_i,
  output logic [WAY_W-1:0] rep_resp_way_o
);

  localparam int unsigned Nodes = WAYS - 1;

  typedef logic [Nodes-1:0] tree_t;

  // Point every node on the path of way w away from w.
  function automatic tree_t touch(input tree_t t, input logic [WAY_W-1:0] w);
    tree_t       r;
    int unsigned node;
    r    = t;
    node = 0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      for (int unsigned j = 0; j < Nodes; j++) begin
        if (j == node) r[j] = ~w[WAY_W-1-l];
      end
      node = 2 * node + 1 + 32'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] walk(input tree_t t);
    logic [WAY_W-1:0] v;
    logic             b;
    int unsigned      node;
    v    = '0;
    node = 0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int unsigned j = 0; j < Nodes; j++) begin
        if (j == node) b = t[j];
      end
      v[WAY_W-1-l] = b;
      node = 2 * node + 1 + 32'(b);
    end
    return v;
  endfunction

  tree_t            tree_q [SETS];
  tree_t            tree_d [SETS];
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WAY_W-1:0] resp_way_q, resp_way_d;

  logic             hit_en;
  logic             accept;
  tree_t            hit_tree;
  tree_t            sel_tree;
  tree_t            vic_tree;
  logic [WAY_W-1:0] victim;

  assign rep_req_ready_o  = ~busy_q & (~resp_valid_q | rep_resp_ready_i);
  assign accept           = rep_req_valid_i & rep_req_ready_o;
  assign hit_en           = hit_valid_i & ~busy_q;
  assign plru_busy_o      = busy_q;
  assign rep_resp_valid_o = resp_valid_q;
  assign rep_resp_way_o   = resp_way_q;

  // Victim sees a same-cycle same-set hit so the hit touch is applied first.
  always_comb begin
    hit_tree = touch(tree_q[hit_index_i], hit_way_i);
    sel_tree = (hit_en && (hit_index_i == rep_req_index_i)) ? hit_tree
                                                            : tree_q[rep_req_index_i];
    victim   = walk(sel_tree);
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!rep_req_vmask_i[i]) victim = WAY_W'(i);
    end
`endif
    vic_tree = touch(sel_tree, victim);
  end

  always_comb begin
    tree_d       = tree_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_way_d   = resp_way_q;

    if (busy_q) begin
      tree_d[cnt_q] = '0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(SETS - 1)) busy_d = 1'b0;
    end else begin
      if (hit_en) tree_d[hit_index_i] = hit_tree;
      // Written after the hit so the victim touch wins on a shared set.
      if (accept) tree_d[rep_req_index_i] = vic_tree;
      if (flush_valid_i) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end
    end

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_way_d   = victim;
    end else if (rep_resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SETS; i++) tree_q[i] <= '0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
    end else begin
      tree_q       <= tree_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
    end
  end

endmodule

// File: tb/tb_icache_plru_tree.sv
// Directed self-checking bench for icache_plru_tree (8 ways, 64 sets).
// Covers the ICACHE_PLRU_INVALID_FIRST_EN feature when that macro is defined.
module tb_icache_plru_tree;

  localparam int IDX_W = 6;
  localparam int WAY_W = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_valid_i = 1'b0;
  logic             plru_busy_o;
  logic             hit_valid_i = 1'b0;
  logic [IDX_W-1:0] hit_index_i = '0;
  logic [WAY_W-1:0] hit_way_i = '0;
  logic             rep_req_valid_i = 1'b0;
  logic             rep_req_ready_o;
  logic [IDX_W-1:0] rep_req_index_i = '0;
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
  logic [7:0]       rep_req_vmask_i = 8'hFF;
`endif
  logic             rep_resp_valid_o;
  logic             rep_resp_ready_i = 1'b0;
  logic [WAY_W-1:0] rep_resp_way_o;

  int checks = 0;
  int failures = 0;
  int n;
  int exp_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  icache_plru_tree #(
    .WAYS(8),
    .SETS(64)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_valid_i   (flush_valid_i),
    .plru_busy_o     (plru_busy_o),
    .hit_valid_i     (hit_valid_i),
    .hit_index_i     (hit_index_i),
    .hit_way_i       (hit_way_i),
    .rep_req_valid_i (rep_req_valid_i),
    .rep_req_ready_o (rep_req_ready_o),
    .rep_req_index_i (rep_req_index_i),
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    .rep_req_vmask_i (rep_req_vmask_i),
`endif
    .rep_resp_valid_o(rep_resp_valid_o),
    .rep_resp_ready_i(rep_resp_ready_i),
    .rep_resp_way_o  (rep_resp_way_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one request, check the 1-cycle response, then consume it.
  task automatic req(input logic [IDX_W-1:0] idx, input int exp, input string tag);
    chk({tag, "_rdy"}, 32'(rep_req_ready_o), 1);
    rep_req_valid_i = 1'b1;
    rep_req_index_i = idx;
    step();
    rep_req_valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(rep_resp_valid_o), 1);
    chk({tag, "_way"}, 32'(rep_resp_way_o), exp);
    rep_resp_ready_i = 1'b1;
    step();
    rep_resp_ready_i = 1'b0;
    chk({tag, "_clr"}, 32'(rep_resp_valid_o), 0);
  endtask

  task automatic hit(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way);
    hit_valid_i = 1'b1;
    hit_index_i = idx;
    hit_way_i   = way;
    step();
    hit_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_resp_valid", 32'(rep_resp_valid_o), 0);
    chk("rst_resp_way", 32'(rep_resp_way_o), 0);
    chk("rst_busy", 32'(plru_busy_o), 0);
    chk("rst_req_ready", 32'(rep_req_ready_o), 1);
    rst_ni = 1'b1;
    step();

    // Successive victims of set 5 cycle through all ways.
    foreach (exp_seq[i]) req(6'd5, exp_seq[i], $sformatf("seq5_%0d", i));

    // Touching 0..6 in order leaves the root pointing left (touch of 6), landing on way 0.
    for (int w = 0; w < 7; w++) hit(6'd9, WAY_W'(w));
    req(6'd9, 0, "hits9");
    req(6'd10, 0, "fresh10");

    // Back-pressure on set 3.
    rep_req_valid_i = 1'b1;
    rep_req_index_i = 6'd3;
    step();
    chk("bp_vld0", 32'(rep_resp_valid_o), 1);
    chk("bp_way0", 32'(rep_resp_way_o), 0);
    chk("bp_rdy0", 32'(rep_req_ready_o), 0);
    step();
    chk("bp_vld1", 32'(rep_resp_valid_o), 1);
    chk("bp_way1", 32'(rep_resp_way_o), 0);
    chk("bp_rdy1", 32'(rep_req_ready_o), 0);
    rep_resp_ready_i = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(rep_req_ready_o), 1);
    step();
    rep_req_valid_i = 1'b0;
    chk("bp_vld2", 32'(rep_resp_valid_o), 1);
    chk("bp_way2", 32'(rep_resp_way_o), 4);
    step();
    rep_resp_ready_i = 1'b0;
    chk("bp_clr", 32'(rep_resp_valid_o), 0);

    // Same-cycle hit way 0 and request on set 2.
    hit_valid_i     = 1'b1;
    hit_index_i     = 6'd2;
    hit_way_i       = 3'd0;
    rep_req_valid_i = 1'b1;
    rep_req_index_i = 6'd2;
    step();
    hit_valid_i     = 1'b0;
    rep_req_valid_i = 1'b0;
    chk("byp_way", 32'(rep_resp_way_o), 4);
    rep_resp_ready_i = 1'b1;
    step();
    rep_resp_ready_i = 1'b0;
    req(6'd2, 2, "byp_next");

    // Flush with a held response on set 5.
    rep_req_valid_i = 1'b1;
    rep_req_index_i = 6'd5;
    step();
    rep_req_valid_i = 1'b0;
    chk("fl_held_way", 32'(rep_resp_way_o), 0);
    flush_valid_i = 1'b1;
    step();
    flush_valid_i = 1'b0;
    chk("fl_busy", 32'(plru_busy_o), 1);
    chk("fl_held_vld", 32'(rep_resp_valid_o), 1);
    chk("fl_req_rdy", 32'(rep_req_ready_o), 0);
    hit_valid_i = 1'b1;
    hit_index_i = 6'd5;
    hit_way_i   = 3'd0;
    n = 0;
    while (plru_busy_o && n < 200) begin
      if (n == 10) rep_resp_ready_i = 1'b1;
      if (n == 11) begin
        chk("fl_consume", 32'(rep_resp_valid_o), 0);
        rep_resp_ready_i = 1'b0;
      end
      if (n == 20) flush_valid_i = 1'b1;
      if (n == 21) flush_valid_i = 1'b0;
      step();
      n++;
    end
    hit_valid_i = 1'b0;
    chk("fl_len", 32'(n), 64);
    req(6'd5, 0, "fl_set5");
    req(6'd9, 0, "fl_set9");
    req(6'd2, 0, "fl_set2");

`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    rep_req_vmask_i = 8'hFB;
    req(6'd7, 2, "inv_fb");
    rep_req_vmask_i = 8'hFF;
    req(6'd7, 4, "inv_ff");
`endif

    // Asynchronous reset mid-sweep with a held response.
    rep_req_valid_i = 1'b1;
    rep_req_index_i = 6'd12;
    step();
    rep_req_valid_i = 1'b0;
    chk("ar_held", 32'(rep_resp_valid_o), 1);
    flush_valid_i = 1'b1;
    step();
    flush_valid_i = 1'b0;
    chk("ar_busy", 32'(plru_busy_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_busy0", 32'(plru_busy_o), 0);
    chk("ar_vld0", 32'(rep_resp_valid_o), 0);
    chk("ar_way0", 32'(rep_resp_way_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    req(6'd2, 0, "ar_set2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
